// File: rtl/bongo_pkg.sv
// bongo_pkg: FSM states and protocol constants shared by the bongo poll sequencer.
package bongo_pkg;
   typedef enum logic [2:0] {IDLE, TX_BIT, TX_STOP, RX_WAIT, RX_SAMPLE, DONE, ERR} state_t;
   localparam int CMD_BITS  = 24;
   localparam int RESP_BITS = 64;
   localparam logic [CMD_BITS-1:0] POLL_CMD = 24'h400300;
   localparam int LOW0_US   = 3;
   localparam int LOW1_US   = 1;
   localparam int BIT_US    = 4;
   localparam int STOP_US   = 1;
   localparam int SAMPLE_US = 2;
endpackage

// File: rtl/bongo_us_timer.sv
// bongo_us_timer: microsecond prescaler plus saturating elapsed-us counter, cleared on state entry.
module bongo_us_timer #(
   parameter int CYC_PER_US = 50,
   parameter int MAX_US     = 10000,
   parameter int UW         = $clog2(MAX_US + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   output logic          us_tick,
   output logic [UW-1:0] us_cnt
);
   localparam int PW = CYC_PER_US > 1 ? $clog2(CYC_PER_US) : 1;
   logic [PW-1:0] pre_q, pre_d;
   logic [UW-1:0] us_q, us_d;
   assign us_tick = pre_q == PW'(CYC_PER_US - 1);
   assign us_cnt  = us_q;
   always_comb begin
      pre_d = (clr || us_tick) ? '0 : pre_q + 1'b1;
      us_d  = clr ? '0 : (us_tick && us_q != UW'(MAX_US)) ? us_q + 1'b1 : us_q;
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         pre_q <= '0;
         us_q  <= '0;
      end else begin
         pre_q <= pre_d;
         us_q  <= us_d;
      end
endmodule

// File: rtl/bongo_poll_sequencer.sv
// bongo_poll_sequencer: periodic poll command / 64-bit response master for the single-wire
// bongo/GameCube link; open-drain pad control plus latched response and timeout pulses.
module bongo_poll_sequencer
   import bongo_pkg::*;
#(
   parameter int CYC_PER_US       = 50,
   parameter int POLL_INTERVAL_US = 10000,
   parameter int TIMEOUT_US       = 100
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 poll_en,
   input  logic                 rumble,
   input  logic                 data_in,
   output logic                 data_oe,
   output logic [RESP_BITS-1:0] resp_data,
   output logic                 resp_valid,
   output logic                 timeout_err,
   output logic                 busy
);
   localparam int MAX_US = POLL_INTERVAL_US > TIMEOUT_US ? POLL_INTERVAL_US : TIMEOUT_US;
   localparam int UW     = $clog2(MAX_US + 1);
   localparam int IW     = $clog2(CMD_BITS);
   localparam int RW     = $clog2(RESP_BITS);

   state_t               state_q, state_d;
   logic [2:0]           sync_q, sync_d;
   logic [CMD_BITS-1:0]  cmd_q, cmd_d;
   logic [IW-1:0]        bit_idx_q, bit_idx_d;
   logic [RW-1:0]        rx_cnt_q, rx_cnt_d;
   logic [RESP_BITS-1:0] sr_q, sr_d, resp_q, resp_d;
   logic                 armed_q, armed_d;
   logic                 clr, us_tick, fall;
   logic [UW-1:0]        us_cnt;

   bongo_us_timer #(.CYC_PER_US(CYC_PER_US), .MAX_US(MAX_US), .UW(UW)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (clr),
      .us_tick (us_tick),
      .us_cnt  (us_cnt)
   );

   // sync_q[1] is the synchronized level, sync_q[2] its one-cycle history
   assign fall        = sync_q[2] & ~sync_q[1];
   assign resp_data   = resp_q;
   assign resp_valid  = state_q == DONE;
   assign timeout_err = state_q == ERR;
   assign busy        = state_q inside {TX_BIT, TX_STOP, RX_WAIT, RX_SAMPLE};

   always_comb begin
      state_d   = state_q;
      sync_d    = {sync_q[1:0], data_in};
      cmd_d     = cmd_q;
      bit_idx_d = bit_idx_q;
      rx_cnt_d  = rx_cnt_q;
      sr_d      = sr_q;
      resp_d    = resp_q;
      armed_d   = armed_q;
      clr       = 1'b0;
      data_oe   = 1'b0;
      case (state_q)
         IDLE:
            if (poll_en && (armed_q || us_cnt >= UW'(POLL_INTERVAL_US))) begin
               state_d   = TX_BIT;
               cmd_d     = POLL_CMD | CMD_BITS'(rumble);
               bit_idx_d = IW'(CMD_BITS - 1);
               armed_d   = 1'b0;
            end
         TX_BIT: begin
            data_oe = us_cnt < UW'(cmd_q[bit_idx_q] ? LOW1_US : LOW0_US);
            if (us_tick && us_cnt == UW'(BIT_US - 1)) begin
               clr       = 1'b1;
               state_d   = bit_idx_q == '0 ? TX_STOP : TX_BIT;
               bit_idx_d = bit_idx_q - 1'b1;
            end
         end
         TX_STOP: begin
            data_oe = 1'b1;
            if (us_tick && us_cnt == UW'(STOP_US - 1)) begin
               state_d  = RX_WAIT;
               rx_cnt_d = '0;
            end
         end
         RX_WAIT:
            state_d = fall ? RX_SAMPLE :
                      (us_tick && us_cnt == UW'(TIMEOUT_US - 1)) ? ERR : RX_WAIT;
         RX_SAMPLE:
            if (us_tick && us_cnt == UW'(SAMPLE_US - 1)) begin
               sr_d     = {sr_q[RESP_BITS-2:0], sync_q[1]};
               rx_cnt_d = rx_cnt_q + 1'b1;
               state_d  = rx_cnt_q == RW'(RESP_BITS - 1) ? DONE : RX_WAIT;
               resp_d   = rx_cnt_q == RW'(RESP_BITS - 1) ? sr_d : resp_q;
            end
         default: state_d = IDLE;
      endcase
      clr = clr | (state_d != state_q);
   end

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state_q   <= IDLE;
         sync_q    <= '1;
         cmd_q     <= '0;
         bit_idx_q <= '0;
         rx_cnt_q  <= '0;
         sr_q      <= '0;
         resp_q    <= '0;
         armed_q   <= 1'b1;
      end else begin
         state_q   <= state_d;
         sync_q    <= sync_d;
         cmd_q     <= cmd_d;
         bit_idx_q <= bit_idx_d;
         rx_cnt_q  <= rx_cnt_d;
         sr_q      <= sr_d;
         resp_q    <= resp_d;
         armed_q   <= armed_d;
      end
endmodule

// File: tb/tb_bongo_poll_sequencer.sv
// tb_bongo_poll_sequencer: decodes the pad, emulates a controller, scoreboards responses/timeouts.
module tb_bongo_poll_sequencer;
   import bongo_pkg::*;
   localparam int CYC     = 4;
   localparam int POLL_US = 50;
   localparam int TO_US   = 20;

   typedef struct packed {
      logic        is_to;
      logic [63:0] val;
   } evt_t;

   logic        clk, rst, poll_en, rumble, data_in, data_oe;
   logic [63:0] resp_data;
   logic        resp_valid, timeout_err, busy;
   logic        dev_low;

   int          n_cmp, n_bad, cyc, rel_cyc, evt_cnt, stop_cnt, low_len, nbits;
   evt_t        exp_evt[$];
   logic [23:0] exp_cmd[$];
   logic [23:0] cmd_rx;
   logic [63:0] last_model, plan_val;
   bit          plan_reply, len_ok, busy_ok, rv_prev;
   int          plan_dly;
   event        stop_ev;

   bongo_poll_sequencer #(.CYC_PER_US(CYC), .POLL_INTERVAL_US(POLL_US), .TIMEOUT_US(TO_US)) dut (
      .clk         (clk),
      .rst         (rst),
      .poll_en     (poll_en),
      .rumble      (rumble),
      .data_in     (data_in),
      .data_oe     (data_oe),
      .resp_data   (resp_data),
      .resp_valid  (resp_valid),
      .timeout_err (timeout_err),
      .busy        (busy)
   );

   assign data_in = ~(data_oe | dev_low);

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Pad decoder: low-pulse length gives the command bit; the 25th pulse is the stop bit.
   always @(negedge clk) begin
      if (!rst) begin
         low_len = 0;
         nbits   = 0;
         len_ok  = 1;
         busy_ok = 1;
      end else if (data_oe) low_len++;
      else if (low_len > 0) begin
         if (nbits < CMD_BITS) begin
            len_ok  &= (low_len == CYC || low_len == 3 * CYC);
            busy_ok &= busy;
            cmd_rx   = {cmd_rx[22:0], low_len == CYC};
            nbits++;
            if (nbits == CMD_BITS) begin
               if (exp_cmd.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL cmd_unexpected: got %h, expected none", cmd_rx);
               end else chk("cmd", 64'(cmd_rx), 64'(exp_cmd.pop_front()));
            end
         end else begin
            chk("stop_len", 64'(low_len), 64'(CYC));
            chk("tx_busy_len", 64'({busy_ok, len_ok}), 64'd3);
            nbits   = 0;
            len_ok  = 1;
            busy_ok = 1;
            rel_cyc = cyc;
            stop_cnt++;
            -> stop_ev;
         end
         low_len = 0;
      end
   end

   // Response/timeout monitor
   always @(negedge clk) begin
      if (rst && (resp_valid || timeout_err)) begin
         evt_t e;
         evt_cnt++;
         if (exp_evt.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL evt_unexpected: got valid=%b timeout=%b, expected none", resp_valid, timeout_err);
         end else begin
            e = exp_evt.pop_front();
            chk("evt_kind", 64'({resp_valid, timeout_err}), 64'({!e.is_to, e.is_to}));
            chk("resp_data", resp_data, e.val);
            if (resp_valid) begin
               chk("rv_pulse", 64'(rv_prev), 64'd0);
               chk("rv_busy", 64'(busy), 64'd0);
            end else chk("to_delay", 64'(cyc - rel_cyc), 64'(TO_US * CYC));
         end
      end
      rv_prev = resp_valid;
   end

   // Controller model: replies MSB first, 4 us per bit, then a 1 us stop bit
   initial begin
      logic [63:0] v;
      dev_low = 1'b0;
      forever begin
         @stop_ev;
         if (plan_reply) begin
            v = plan_val;
            repeat (plan_dly * CYC) @(negedge clk);
            for (int i = 63; i >= 0; i--) begin
               dev_low = 1'b1;
               repeat ((v[i] ? 1 : 3) * CYC) @(negedge clk);
               dev_low = 1'b0;
               repeat ((v[i] ? 3 : 1) * CYC) @(negedge clk);
            end
            dev_low = 1'b1;
            repeat (CYC) @(negedge clk);
            dev_low = 1'b0;
         end
      end
   end

   // mode: 0 plain, 1 drop rumble mid-command, 2 drop poll_en during RX, 3 reset mid-TX
   task automatic txn(input logic rmb, input bit reply, input logic [63:0] val, input int dly, input int mode);
      int  n0, s0, t;
      bit  act;
      poll_en    = 1'b1;
      rumble     = rmb;
      plan_reply = reply;
      plan_val   = val;
      plan_dly   = dly;
      exp_cmd.push_back(POLL_CMD | 24'(rmb));
      if (reply) last_model = val;
      exp_evt.push_back('{is_to: !reply, val: last_model});
      n0 = evt_cnt;
      s0 = stop_cnt;
      t  = 0;
      while (!busy && t < 2000) begin @(negedge clk); t++; end
      chk("busy_start", 64'(busy), 64'd1);
      if (mode == 1) begin
         repeat (20) @(negedge clk);
         rumble = 1'b0;
      end
      if (mode == 2) begin
         t = 0;
         while (stop_cnt == s0 && t < 2000) begin @(negedge clk); t++; end
         repeat (10) @(negedge clk);
         poll_en = 1'b0;
      end
      if (mode == 3) begin
         repeat (30) @(negedge clk);
         t = 0;
         while (!data_oe && t < 100) begin @(negedge clk); t++; end
         #2 rst = 1'b0;
         #1;
         chk("rst_outs", 64'({data_oe, resp_valid, timeout_err, busy}), 64'd0);
         chk("rst_resp", resp_data, 64'd0);
         repeat (3) @(negedge clk);
         rst = 1'b1;
         t = 0;
         while (!busy && t < 2000) begin @(negedge clk); t++; end
         chk("busy_restart", 64'(busy), 64'd1);
      end
      t = 0;
      while (evt_cnt == n0 && t < 6000) begin @(negedge clk); t++; end
      chk("evt_seen", 64'(evt_cnt != n0), 64'd1);
      if (mode == 2) begin
         act = 0;
         repeat (3 * POLL_US * CYC + 20) begin
            @(negedge clk);
            act |= busy | data_oe;
         end
         chk("quiet", 64'(act), 64'd0);
      end
   endtask

   initial begin
      n_cmp = 0; n_bad = 0; cyc = 0; rel_cyc = 0; evt_cnt = 0; stop_cnt = 0;
      low_len = 0; nbits = 0; cmd_rx = '0; last_model = '0; rv_prev = 0;
      plan_reply = 0; plan_val = '0; plan_dly = 0;
      rst = 1'b0; poll_en = 1'b0; rumble = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outs", 64'({data_oe, resp_valid, timeout_err, busy}), 64'd0);
      chk("reset_resp", resp_data, 64'd0);
      rst = 1'b1;
      txn(1'b0, 1'b1, 64'h0080_8080_8000_0000, 2, 0);
      txn(1'b0, 1'b0, 64'd0, 0, 0);
      txn(1'b1, 1'b1, {$urandom, $urandom}, 3, 1);
      repeat (6) txn(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, {$urandom, $urandom},
                     $urandom_range(1, 8), 0);
      txn(1'b0, 1'b1, {$urandom, $urandom}, 4, 2);
      txn(1'b0, 1'b1, {$urandom, $urandom}, 2, 3);
      chk("evt_left", 64'(exp_evt.size()), 64'd0);
      chk("cmd_left", 64'(exp_cmd.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not complete, %0d compared / %0d mismatched so far", n_cmp, n_bad);
      $fatal(1);
   end
endmodule
